uart_rx: RTL

//  8N1 RS232 receiver behind the board pin RS232_RX_IN; in the bench, TX loops back to RX.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync_2ff.sv | 33 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM states, default bit timing, data width.
// Kept in one package so uart_tx can reuse the same constants.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_W               = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs (serial line, buttons, switches).
// RESET_VAL sets the flops to the input's idle level so reset creates no false edge.
module sync_2ff #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises the line, validates the start bit, samples mid-bit
// and hands each byte over through a one-entry valid/ready holding register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              CLK,
  input  logic              RST_SYNC,
  input  logic              RS232_RX_IN,
  output logic [DATA_W-1:0] RX_DATA_OUT,
  output logic              RX_VALID_OUT,
  input  logic              RX_READY_IN,
  output logic              FRAME_ERR_OUT,
  output logic              OVERRUN_OUT,
  output logic              BUSY_OUT
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (CLK),
    .rst (RST_SYNC),
    .d   (RS232_RX_IN),
    .q   (rx_s)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // The counter restarts at every sample point, so each sample lands exactly
  // one bit period after the previous one, starting from the start-bit midpoint.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && RX_READY_IN) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            // A full register may still take the new byte if it is being drained this cycle.
            if (!valid_q || RX_READY_IN) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign RX_DATA_OUT   = data_q;
  assign RX_VALID_OUT  = valid_q;
  assign FRAME_ERR_OUT = frame_err_q;
  assign OVERRUN_OUT   = overrun_q;
  assign BUSY_OUT      = (state_q != ST_IDLE);

endmodule
